ped_request_ctrl: RTL
=====================

# ped_request_ctrl

Front-end stage for the pedestrian traffic light. Runs on the fast board clock and conditions the raw pedestrian push-button: synchronises it, debounces it, and flags a stuck button. It turns a press into a held crossing request that stays up until the light controller acknowledges it, and it generates the 1 Hz timing tick that paces the light controller's phase counters.

## Interface
- DEBOUNCE_CYC, 1_000_000: consecutive stable clk cycles needed to accept a new button level (≥2).
- TICK_DIV, 50_000_000: clk cycles per tick period (≥2).
- STUCK_TICKS, 10: ticks of continuous debounced press before the button is declared stuck (1..255).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  1  raw button, asynchronous, active high.
- ack  in  1  from light controller: level, high while the pedestrian-green phase is active.
- tick  out  1  one-cycle pulse, once per TICK_DIV cycles.
- btn_db  out  1  debounced button level.
- req  out  1  held crossing request.
- stuck  out  1  stuck-button fault.

## Operation
- Reset: all outputs 0. Sync flops, debounce counter, tick counter and stuck counter are 0. FSM is in IDLE.
- Synchroniser: two flops on btn_raw give btn_s.
- Debounce counter (width $clog2(DEBOUNCE_CYC)):
  - Clears whenever btn_s == btn_db.
  - Otherwise increments.
  - When it reaches DEBOUNCE_CYC-1 with btn_s != btn_db, btn_db takes btn_s and the counter clears.
- Press event: btn_db rising edge AND stuck==0.
- Tick counter (width $clog2(TICK_DIV)):
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (count == TICK_DIV-1), registered-decoded with no combinational path from inputs.
  - Free-running: independent of button and FSM.
- Stuck counter (8 bit):
  - Clears when btn_db==0.
  - Increments on tick while btn_db==1, saturating at STUCK_TICKS.
  - stuck=1 when count == STUCK_TICKS. It clears on the cycle after btn_db falls.
- Request FSM, states IDLE, PENDING, SERVED:
  - IDLE: on press event -> PENDING. ack is ignored in IDLE.
  - PENDING: req=1. On ack=1 -> SERVED. Press events are ignored (no queuing).
  - SERVED: req=0. Press events are ignored. On ack=0 -> IDLE.
  - Encodings outside these three states -> IDLE.
- Simultaneous events:
  - Press and ack in IDLE: the press is taken, -> PENDING.
  - ack in PENDING: -> SERVED regardless of any press.
  - stuck asserting while PENDING: req stays held. Stuck only blocks new presses.
- Reset mid-operation returns everything to the reset state immediately (asynchronous). A press in progress is lost.

## Timing
- btn_db rises DEBOUNCE_CYC+2 clk edges after btn_raw rises stably. This covers 2 synchroniser cycles plus DEBOUNCE_CYC stable cycles. The falling edge has the same latency.
- Any glitch shorter than DEBOUNCE_CYC cycles is fully rejected.
- req rises 1 cycle after btn_db rises.
- req falls 1 cycle after ack is sampled high.
- First tick: cycle TICK_DIV-1 after rst_n deassertion. Thereafter exactly TICK_DIV cycles apart.
- stuck rises 1 cycle after the tick that brings the stuck count to STUCK_TICKS.
- All outputs are registered.

## Structure
- Shared package ped_pkg holds:
  - FSM state encodings: IDLE=2'd0, PENDING=2'd1, SERVED=2'd2.
  - Default DEBOUNCE_CYC, TICK_DIV and STUCK_TICKS constants, reused by the light controller.
- Sub-module ped_debounce (parameter DEBOUNCE_CYC) contains the synchroniser, the debounce counter and the rising-edge output. It is reusable for future pedestrian buttons.
- The top level holds the tick divider, the stuck counter and the request FSM.

## Test plan
All scenarios use DEBOUNCE_CYC=4, TICK_DIV=10, STUCK_TICKS=3.
- Reset: assert rst_n=0 mid-PENDING -> tick=btn_db=req=stuck=0 immediately. After release, the first tick falls on cycle 9 and then every 10 cycles.
- Clean press: btn_raw 0→1 held 20 cycles -> btn_db high 6 cycles after the edge, req high 1 cycle later. ack high -> req low 1 cycle later. ack low -> FSM back in IDLE.
- Glitch rejection: btn_raw pulses of 1, 2 and 3 cycles separated by 5 idle cycles -> btn_db and req stay 0.
- Ignored presses: second press while PENDING and a press while SERVED -> no extra request. A press after ack falls -> new req.
- Stuck: btn_raw held high for 40 cycles -> stuck=1 one cycle after the 3rd tick following btn_db rise. Release -> stuck=0 one cycle after btn_db falls. A press while stuck (held high through a re-debounce) -> no req.
- Simultaneous: press event and ack=1 in the same cycle in IDLE -> PENDING, req=1. ack=1 while PENDING with a concurrent press -> SERVED, req=0.

Source files
------------

// File: rtl/ped_pkg.sv
// ped_pkg: shared state encodings, default timing constants and sizing helper for the pedestrian crossing blocks
package ped_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] SERVED  = 2'd2;

    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int TICK_DIV_DEF     = 50_000_000;
    localparam int STUCK_TICKS_DEF  = 10;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// ped_debounce: synchronises and debounces one push-button and flags its accepted rising edge
module ped_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam int W = cnt_w(DEBOUNCE_CYC);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYC - 1);

    logic s1;
    logic s2;
    logic [W-1:0] cnt;
    logic flip;

    assign flip = (s2 != btn_db) && (cnt == LAST);

    // two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // count stable disagreeing cycles; accept the new level once the count is complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            btn_db   <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            cnt      <= (s2 == btn_db || flip) ? '0 : cnt + 1'b1;
            btn_db   <= flip ? s2 : btn_db;
            btn_rise <= flip && s2;
        end
    end

endmodule

// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian button front end with held crossing request, 1 Hz tick and stuck-button fault
module ped_request_ctrl
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STUCK_TICKS  = STUCK_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic ack,
    output logic tick,
    output logic btn_db,
    output logic req,
    output logic stuck
);

    localparam int TW = cnt_w(TICK_DIV);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
    localparam logic [7:0] SMAX = 8'(STUCK_TICKS);

    logic btn_rise;
    logic press;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic [7:0] scnt;
    logic [7:0] scnt_n;
    logic [1:0] state;
    logic [1:0] state_n;

    ped_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .btn_rise(btn_rise)
    );

    // a stuck button cannot raise new requests
    assign press  = btn_rise && !stuck;
    assign tcnt_n = (tcnt == TLAST) ? '0 : tcnt + 1'b1;
    assign scnt_n = !btn_db ? '0 : (tick && scnt < SMAX) ? scnt + 8'd1 : scnt;

    // request FSM next state; ack is only honoured once a request is pending
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = press ? PENDING : IDLE;
            PENDING: state_n = ack ? SERVED : PENDING;
            SERVED:  state_n = ack ? SERVED : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // free-running tick divider with the tick decoded from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tcnt <= tcnt_n;
            tick <= (tcnt_n == TLAST);
        end
    end

    // stuck detector: ticks of continuous debounced press, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt  <= '0;
            stuck <= 1'b0;
        end else begin
            scnt  <= scnt_n;
            stuck <= (scnt_n == SMAX);
        end
    end

    // request state and registered request output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req   <= 1'b0;
        end else begin
            state <= state_n;
            req   <= (state_n == PENDING);
        end
    end

endmodule
